// File: rtl/rab_pkg.sv
// Shared types for the RAB lookup stage: error codes and sequencer states.
package rab_pkg;

  typedef enum logic [1:0] {
    RAB_ERR_MISS  = 2'b00,
    RAB_ERR_PROT  = 2'b01,
    RAB_ERR_MULTI = 2'b10,
    RAB_ERR_WRAP  = 2'b11
  } rab_err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FWD,
    ST_ERR
  } rab_lookup_state_e;

  localparam int unsigned MISS_CNT_W = 16;

endpackage

// File: rtl/rab_burst_range.sv
// Combinational burst range: last byte address of an AXI burst plus the
// carry out of the virtual address space (wrap).
module rab_burst_range #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  output logic [ADDR_WIDTH-1:0] o_max,
  output logic                  o_wrap
);

  logic [8:0]          w_beats;
  logic [ADDR_WIDTH:0] w_span;
  logic [ADDR_WIDTH:0] w_end;

  // span = beats << size, end = start + span - 1, all one bit wider than the address
  always_comb begin
    w_beats = {1'b0, i_len} + 9'd1;
    w_span  = {{(ADDR_WIDTH-8){1'b0}}, w_beats} << i_size;
    w_end   = {1'b0, i_addr} + w_span - (ADDR_WIDTH+1)'(1);
    o_max   = w_end[ADDR_WIDTH-1:0];
    o_wrap  = w_end[ADDR_WIDTH];
  end

endmodule

// File: rtl/rab_lookup_stage.sv
// Per-channel request sequencer around the RAB slice array: captures one
// address-channel request, looks it up, then forwards it or reports an error.
module rab_lookup_stage
  import rab_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_VIRT = 32,
  parameter int unsigned ADDR_WIDTH_PHYS = 40,
  parameter int unsigned N_SLICES        = 16,
  parameter int unsigned ID_WIDTH        = 8
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RBI,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH_VIRT-1:0] in_addr,
  input  logic [7:0]                 in_len,
  input  logic [2:0]                 in_size,
  input  logic [ID_WIDTH-1:0]        in_id,
  input  logic                       in_rw,
  output logic                       lookup_rw,
  output logic [ADDR_WIDTH_VIRT-1:0] lookup_addr_min,
  output logic [ADDR_WIDTH_VIRT-1:0] lookup_addr_max,
  input  logic [N_SLICES-1:0]        lookup_hit,
  input  logic [N_SLICES-1:0]        lookup_prot,
  input  logic                       lookup_multi_hit,
  input  logic [ADDR_WIDTH_PHYS-1:0] lookup_out_addr,
  input  logic                       lookup_cache_coherent,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH_PHYS-1:0] out_addr,
  output logic [7:0]                 out_len,
  output logic [2:0]                 out_size,
  output logic [ID_WIDTH-1:0]        out_id,
  output logic                       out_cc,
  output logic                       err_valid,
  input  logic                       err_ready,
  output logic [1:0]                 err_type,
  output logic [ADDR_WIDTH_VIRT-1:0] err_addr,
  output logic [ID_WIDTH-1:0]        err_id,
  output logic                       err_rw,
  output logic [MISS_CNT_W-1:0]      miss_cnt,
  input  logic                       cnt_clr
);

  rab_lookup_state_e r_state, w_state_nxt;

  logic [ADDR_WIDTH_VIRT-1:0] r_addr, r_max;
  logic [7:0]                 r_len;
  logic [2:0]                 r_size;
  logic [ID_WIDTH-1:0]        r_id;
  logic                       r_rw;
  logic [ADDR_WIDTH_PHYS-1:0] r_phys;
  logic                       r_cc;
  rab_err_e                   r_err_type;
  logic [MISS_CNT_W-1:0]      r_miss_cnt, w_miss_cnt_nxt;

  logic [ADDR_WIDTH_VIRT-1:0] w_max;
  logic                       w_wrap;
  logic                       w_accept;
  logic                       w_lookup_ok;
  logic                       w_miss_inc;
  rab_err_e                   w_lookup_err;

  rab_burst_range #(
    .ADDR_WIDTH(ADDR_WIDTH_VIRT)
  ) u_range (
    .i_addr (in_addr),
    .i_len  (in_len),
    .i_size (in_size),
    .o_max  (w_max),
    .o_wrap (w_wrap)
  );

  // Lookup verdict: a single clean hit forwards, otherwise classify by priority
  always_comb begin
    w_accept     = in_valid && (r_state == ST_IDLE);
    w_lookup_ok  = (|lookup_hit) && !lookup_multi_hit;
    w_lookup_err = RAB_ERR_MISS;
    if (lookup_multi_hit)  w_lookup_err = RAB_ERR_MULTI;
    else if (|lookup_prot) w_lookup_err = RAB_ERR_PROT;
    w_miss_inc   = (r_state == ST_LOOKUP) && !w_lookup_ok && (w_lookup_err == RAB_ERR_MISS);
  end

  // FSM state register
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = w_wrap ? ST_ERR : ST_LOOKUP;
      ST_LOOKUP: w_state_nxt = w_lookup_ok ? ST_FWD : ST_ERR;
      ST_FWD:    if (out_ready) w_state_nxt = ST_IDLE;
      ST_ERR:    if (err_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake strobes decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    err_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: in_ready  = 1'b1;
      ST_FWD:  out_valid = 1'b1;
      ST_ERR:  err_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture on accept; translation result and error code captured in LOOKUP
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_addr     <= '0;
      r_max      <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_id       <= '0;
      r_rw       <= 1'b0;
      r_phys     <= '0;
      r_cc       <= 1'b0;
      r_err_type <= RAB_ERR_MISS;
    end else begin
      if (w_accept) begin
        r_addr <= in_addr;
        r_max  <= w_max;
        r_len  <= in_len;
        r_size <= in_size;
        r_id   <= in_id;
        r_rw   <= in_rw;
        if (w_wrap) r_err_type <= RAB_ERR_WRAP;
      end
      if (r_state == ST_LOOKUP) begin
        if (w_lookup_ok) begin
          r_phys <= lookup_out_addr;
          r_cc   <= lookup_cache_coherent;
        end else begin
          r_err_type <= w_lookup_err;
        end
      end
    end
  end

  // Saturating miss counter; clear takes precedence over a same-cycle miss
  always_comb begin
    w_miss_cnt_nxt = r_miss_cnt;
    if (cnt_clr)                         w_miss_cnt_nxt = '0;
    else if (w_miss_inc && r_miss_cnt != '1) w_miss_cnt_nxt = r_miss_cnt + 1'b1;
  end

  // Miss counter register
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) r_miss_cnt <= '0;
    else          r_miss_cnt <= w_miss_cnt_nxt;
  end

  assign lookup_rw       = r_rw;
  assign lookup_addr_min = r_addr;
  assign lookup_addr_max = r_max;
  assign out_addr        = r_phys;
  assign out_len         = r_len;
  assign out_size        = r_size;
  assign out_id          = r_id;
  assign out_cc          = r_cc;
  assign err_type        = r_err_type;
  assign err_addr        = r_addr;
  assign err_id          = r_id;
  assign err_rw          = r_rw;
  assign miss_cnt        = r_miss_cnt;

endmodule

// File: tb/tb_rab_lookup_stage.sv
// Scoreboard bench for rab_lookup_stage: stimulus pushes hand-computed
// expected responses, a negedge monitor compares whenever an output is presented.
module tb_rab_lookup_stage;

  logic        Clk_CI, Rst_RBI;
  logic        in_valid, in_ready;
  logic [31:0] in_addr;
  logic [7:0]  in_len;
  logic [2:0]  in_size;
  logic [7:0]  in_id;
  logic        in_rw;
  logic        lookup_rw;
  logic [31:0] lookup_addr_min, lookup_addr_max;
  logic [15:0] lookup_hit, lookup_prot;
  logic        lookup_multi_hit;
  logic [39:0] lookup_out_addr;
  logic        lookup_cache_coherent;
  logic        out_valid, out_ready;
  logic [39:0] out_addr;
  logic [7:0]  out_len;
  logic [2:0]  out_size;
  logic [7:0]  out_id;
  logic        out_cc;
  logic        err_valid, err_ready;
  logic [1:0]  err_type;
  logic [31:0] err_addr;
  logic [7:0]  err_id;
  logic        err_rw;
  logic [15:0] miss_cnt;
  logic        cnt_clr;

  rab_lookup_stage #(
    .ADDR_WIDTH_VIRT(32),
    .ADDR_WIDTH_PHYS(40),
    .N_SLICES(16),
    .ID_WIDTH(8)
  ) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_len(in_len),
    .in_size(in_size), .in_id(in_id), .in_rw(in_rw),
    .lookup_rw(lookup_rw), .lookup_addr_min(lookup_addr_min), .lookup_addr_max(lookup_addr_max),
    .lookup_hit(lookup_hit), .lookup_prot(lookup_prot), .lookup_multi_hit(lookup_multi_hit),
    .lookup_out_addr(lookup_out_addr), .lookup_cache_coherent(lookup_cache_coherent),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_len(out_len),
    .out_size(out_size), .out_id(out_id), .out_cc(out_cc),
    .err_valid(err_valid), .err_ready(err_ready), .err_type(err_type), .err_addr(err_addr),
    .err_id(err_id), .err_rw(err_rw), .miss_cnt(miss_cnt), .cnt_clr(cnt_clr)
  );

  typedef struct {
    bit          is_err;
    logic [1:0]  etype;
    logic [31:0] addr;
    logic [31:0] max;
    logic        rw;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [7:0]  id;
    logic [39:0] paddr;
    logic        cc;
    logic [15:0] cnt;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_timeouts = 0;
  int   cyc = 0;
  bit   done = 0;
  bit   fin = 0;

  initial Clk_CI = 1'b0;
  always #5 Clk_CI = ~Clk_CI;
  always @(posedge Clk_CI) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: reset-state checks, acceptance timing, payload against queue head
  initial begin : monitor
    exp_t e;
    int   acc_cyc;
    bit   seen, post_hs;
    acc_cyc = 0; seen = 0; post_hs = 0;
    while (!fin) begin
      @(negedge Clk_CI);
      if (done) begin
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("wait_timeouts", 64'(n_timeouts), 64'd0);
        fin = 1;
      end else if (!Rst_RBI) begin
        q.delete();
        seen = 0; post_hs = 0;
        chk("rst_strobes", 64'({out_valid, err_valid, in_ready}), 64'(3'b001));
        chk("rst_out_payload", 64'({out_addr, out_len, out_size, out_id, out_cc}), 64'd0);
        chk("rst_err_payload", 64'({err_type, err_addr, err_id, err_rw}), 64'd0);
        chk("rst_lookup_addr", {lookup_addr_min, lookup_addr_max}, 64'd0);
        chk("rst_cnt_rw", 64'({miss_cnt, lookup_rw}), 64'd0);
      end else begin
        chk("valid_exclusive", 64'(out_valid && err_valid), 64'd0);
        if (post_hs) begin
          chk("in_ready_after_hs", 64'(in_ready), 64'd1);
          post_hs = 0;
        end
        if (in_valid && in_ready) acc_cyc = cyc;
        if (out_valid || err_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 64'({out_valid, err_valid}), 64'd0);
          end else begin
            e = q[0];
            if (!seen) begin
              chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
              seen = 1;
            end
            chk("kind", 64'({out_valid, err_valid}), e.is_err ? 64'(2'b01) : 64'(2'b10));
            chk("in_ready_busy", 64'(in_ready), 64'd0);
            chk("lookup_min", 64'(lookup_addr_min), 64'(e.addr));
            chk("lookup_max", 64'(lookup_addr_max), 64'(e.max));
            chk("lookup_rw", 64'(lookup_rw), 64'(e.rw));
            chk("miss_cnt", 64'(miss_cnt), 64'(e.cnt));
            if (e.is_err) begin
              chk("err_type", 64'(err_type), 64'(e.etype));
              chk("err_addr", 64'(err_addr), 64'(e.addr));
              chk("err_id", 64'(err_id), 64'(e.id));
              chk("err_rw", 64'(err_rw), 64'(e.rw));
            end else begin
              chk("out_addr", 64'(out_addr), 64'(e.paddr));
              chk("out_len", 64'(out_len), 64'(e.len));
              chk("out_size", 64'(out_size), 64'(e.size));
              chk("out_id", 64'(out_id), 64'(e.id));
              chk("out_cc", 64'(out_cc), 64'(e.cc));
            end
            if ((out_valid && out_ready) || (err_valid && err_ready)) begin
              void'(q.pop_front());
              seen = 0;
              post_hs = 1;
            end
          end
        end
      end
    end
  end

  function automatic exp_t mk(bit is_err, logic [1:0] t, logic [31:0] a, logic [31:0] mx,
                              logic rw, logic [7:0] l, logic [2:0] s, logic [7:0] id,
                              logic [39:0] pa, logic cc, logic [15:0] cnt, int lat);
    exp_t e;
    e.is_err = is_err; e.etype = t; e.addr = a; e.max = mx; e.rw = rw; e.len = l;
    e.size = s; e.id = id; e.paddr = pa; e.cc = cc; e.cnt = cnt; e.lat = lat;
    return e;
  endfunction

  task automatic set_slice(input logic [15:0] hit, input logic [15:0] prot, input logic multi,
                           input logic [39:0] pa, input logic cc);
    lookup_hit = hit; lookup_prot = prot; lookup_multi_hit = multi;
    lookup_out_addr = pa; lookup_cache_coherent = cc;
  endtask

  task automatic drive_req(input exp_t e);
    in_addr = e.addr; in_len = e.len; in_size = e.size; in_id = e.id; in_rw = e.rw;
    in_valid = 1'b1;
  endtask

  // Push expectation, present request, wait (bounded) for acceptance
  task automatic issue(input exp_t e, input bit clr_in_lookup);
    bit ok;
    q.push_back(e);
    drive_req(e);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge Clk_CI);
      if (in_ready) ok = 1;
    end
    if (!ok) n_timeouts++;
    @(posedge Clk_CI); #1;
    in_valid = 1'b0;
    if (clr_in_lookup) begin
      cnt_clr = 1'b1;
      @(posedge Clk_CI); #1;
      cnt_clr = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge Clk_CI);
      if (q.size() == 0) ok = 1;
    end
    if (!ok) n_timeouts++;
    @(posedge Clk_CI); #1;
  endtask

  initial begin : stimulus
    exp_t eb;
    bit   ok;
    Rst_RBI = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_len = '0; in_size = '0; in_id = '0; in_rw = 1'b0;
    out_ready = 1'b1; err_ready = 1'b1; cnt_clr = 1'b0;
    set_slice('0, '0, 1'b0, '0, 1'b0);
    repeat (3) @(posedge Clk_CI);
    #1 Rst_RBI = 1'b1;
    @(posedge Clk_CI); #1;

    // clean hit on slice 2
    set_slice(16'h0004, '0, 1'b0, 40'h80_0000_1000, 1'b0);
    issue(mk(0, 2'b00, 32'h0000_1000, 32'h0000_100F, 1'b0, 8'd3, 3'd2, 8'h11, 40'h80_0000_1000, 1'b0, 16'd0, 2), 0);
    wait_idle();
    // miss
    set_slice('0, '0, 1'b0, 40'h0, 1'b0);
    issue(mk(1, 2'b00, 32'h2000_0040, 32'h2000_0047, 1'b1, 8'd0, 3'd3, 8'h5A, 40'h0, 1'b0, 16'd1, 2), 0);
    wait_idle();
    // protection fault, with error-side backpressure
    err_ready = 1'b0;
    set_slice('0, 16'h0020, 1'b0, 40'h0, 1'b0);
    issue(mk(1, 2'b01, 32'h3000_0000, 32'h3000_003F, 1'b0, 8'd15, 3'd2, 8'h22, 40'h0, 1'b0, 16'd1, 2), 0);
    repeat (4) @(posedge Clk_CI);
    #1 err_ready = 1'b1;
    wait_idle();
    // multi-hit outranks a simultaneous protection flag
    set_slice(16'h0003, 16'h0200, 1'b1, 40'h0, 1'b0);
    issue(mk(1, 2'b10, 32'h4000_0100, 32'h4000_0101, 1'b1, 8'd1, 3'd0, 8'h33, 40'h0, 1'b0, 16'd1, 2), 0);
    wait_idle();
    // wrap: array would hit, but the request never reaches LOOKUP
    set_slice(16'h0001, '0, 1'b0, 40'h11_1111_1111, 1'b0);
    issue(mk(1, 2'b11, 32'hFFFF_FFF0, 32'h0000_000F, 1'b1, 8'd7, 3'd2, 8'h44, 40'h0, 1'b0, 16'd1, 1), 0);
    wait_idle();
    // burst ending exactly at the top of the address space does not wrap
    set_slice(16'h8000, '0, 1'b0, 40'h12_3456_7FE0, 1'b1);
    issue(mk(0, 2'b00, 32'hFFFF_FFE0, 32'hFFFF_FFFF, 1'b0, 8'd7, 3'd2, 8'h55, 40'h12_3456_7FE0, 1'b1, 16'd1, 2), 0);
    wait_idle();
    // largest burst; hit wins over prot flag
    set_slice(16'h0080, 16'h0080, 1'b0, 40'hAB_CDEF_0000, 1'b1);
    issue(mk(0, 2'b00, 32'h1000_0000, 32'h1000_7FFF, 1'b1, 8'd255, 3'd7, 8'h66, 40'hAB_CDEF_0000, 1'b1, 16'd1, 2), 0);
    wait_idle();

    // downstream backpressure with the next request waiting
    out_ready = 1'b0;
    set_slice(16'h0001, '0, 1'b0, 40'h01_0000_0000, 1'b0);
    issue(mk(0, 2'b00, 32'h5000_0000, 32'h5000_001F, 1'b0, 8'd3, 3'd3, 8'h77, 40'h01_0000_0000, 1'b0, 16'd1, 2), 0);
    eb = mk(0, 2'b00, 32'h6000_0000, 32'h6000_0003, 1'b1, 8'd0, 3'd2, 8'h78, 40'h01_0000_0000, 1'b0, 16'd1, 2);
    q.push_back(eb);
    drive_req(eb);
    repeat (10) @(posedge Clk_CI);
    #1 out_ready = 1'b1;
    @(negedge Clk_CI);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge Clk_CI);
      if (in_ready) ok = 1;
    end
    if (!ok) n_timeouts++;
    @(posedge Clk_CI); #1;
    in_valid = 1'b0;
    wait_idle();

    // counter saturation: preload one below the ceiling
    force dut.r_miss_cnt = 16'hFFFE;
    @(posedge Clk_CI); #1;
    release dut.r_miss_cnt;
    set_slice('0, '0, 1'b0, 40'h0, 1'b0);
    issue(mk(1, 2'b00, 32'h0000_2000, 32'h0000_2003, 1'b0, 8'd3, 3'd0, 8'h01, 40'h0, 1'b0, 16'hFFFF, 2), 0);
    wait_idle();
    issue(mk(1, 2'b00, 32'h0000_3000, 32'h0000_3003, 1'b0, 8'd3, 3'd0, 8'h02, 40'h0, 1'b0, 16'hFFFF, 2), 0);
    wait_idle();
    issue(mk(1, 2'b00, 32'h0000_4000, 32'h0000_4003, 1'b1, 8'd3, 3'd0, 8'h03, 40'h0, 1'b0, 16'h0000, 2), 1);
    wait_idle();

    // async reset while a translated request is stalled in FWD
    out_ready = 1'b0;
    set_slice(16'h0010, '0, 1'b0, 40'h77_7777_0000, 1'b1);
    issue(mk(0, 2'b00, 32'h7000_0000, 32'h7000_000F, 1'b1, 8'd3, 3'd2, 8'h09, 40'h77_7777_0000, 1'b1, 16'd0, 2), 0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge Clk_CI);
      if (out_valid) ok = 1;
    end
    if (!ok) n_timeouts++;
    @(posedge Clk_CI); #1;
    Rst_RBI = 1'b0;
    repeat (3) @(posedge Clk_CI);
    #1 Rst_RBI = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge Clk_CI);
    #1;
    // counter restarts from zero after reset
    set_slice('0, '0, 1'b0, 40'h0, 1'b0);
    issue(mk(1, 2'b00, 32'h0000_8000, 32'h0000_8001, 1'b0, 8'd0, 3'd1, 8'h0A, 40'h0, 1'b0, 16'd1, 2), 0);
    wait_idle();

    done = 1;
    for (int i = 0; i < 10 && !fin; i++) @(negedge Clk_CI);
    if (!fin) $display("FAIL monitor_end got=0 exp=1");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
